instr_loader: RTL and testbench

Boot-time instruction encoder and loader for the single-cycle RV32I core. It accepts decoded instruction fields over a valid/ready stream, encodes each into a 32-bit RV32I word, buffers the words in a small FIFO, and writes them sequentially into instruction memory starting at word address 0. While loading, it holds the core in reset. It supports exactly the instruction classes the control unit decodes: lw, sw, R-type ALU, I-type ALU, and beq/bne/blt.

---
 rtl/instr_loader.sv | 194 +++++++++++++++++++
 tb/tb_instr_loader.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_loader.sv
// Boot-time RV32I instruction encoder and loader: encodes decoded field bundles,
// buffers them in a small FIFO and writes them to instruction memory from address 0.
module instr_loader #(
    parameter int AW    = 6,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          in_last,
    input  logic [2:0]    in_kind,
    input  logic [4:0]    in_rd,
    input  logic [4:0]    in_rs1,
    input  logic [4:0]    in_rs2,
    input  logic [2:0]    in_funct3,
    input  logic          in_funct75,
    input  logic [12:0]   in_imm,
    output logic          imem_we,
    input  logic          imem_ready,
    output logic [AW-1:0] imem_addr,
    output logic [31:0]   imem_wdata,
    output logic          cpu_hold,
    output logic          done,
    output logic          err,
    output logic [AW:0]   loaded
);

    localparam int PW = $clog2(DEPTH);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_LOAD  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    localparam logic [2:0] K_LW  = 3'd0;
    localparam logic [2:0] K_SW  = 3'd1;
    localparam logic [2:0] K_R   = 3'd2;
    localparam logic [2:0] K_I   = 3'd3;
    localparam logic [2:0] K_BEQ = 3'd4;
    localparam logic [2:0] K_BNE = 3'd5;
    localparam logic [2:0] K_BLT = 3'd6;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_ALU    = 7'b0110011;
    localparam logic [6:0] OP_ALUI   = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    logic [1:0]    state_q, state_d;
    logic [PW:0]   wr_ptr_q, wr_ptr_d;
    logic [PW:0]   rd_ptr_q, rd_ptr_d;
    logic [31:0]   fifo_q [DEPTH];
    logic [AW-1:0] addr_q, addr_d;
    logic [AW:0]   loaded_q, loaded_d;
    logic          err_q, err_d;
    logic          done_q, done_d;

    logic [31:0]   enc_word;
    logic          enc_legal;
    logic          enc_bad_off;
    logic [2:0]    br_f3;

    logic [PW:0]   count;
    logic [PW:0]   count_next;
    logic          full;
    logic          empty;
    logic          active;
    logic          cap_full;
    logic          accept;
    logic          push;
    logic          pop;
    logic          commit;

    // Branch offsets are halfword-aligned, so imm[0] is never encoded.
    always_comb begin
        enc_word    = '0;
        enc_legal   = 1'b1;
        enc_bad_off = 1'b0;
        if (in_kind == K_BEQ) begin
            br_f3 = 3'b000;
        end else if (in_kind == K_BNE) begin
            br_f3 = 3'b001;
        end else begin
            br_f3 = 3'b100;
        end
        case (in_kind)
            K_LW:  enc_word = {in_imm[11:0], in_rs1, 3'b010, in_rd, OP_LOAD};
            K_SW:  enc_word = {in_imm[11:5], in_rs2, in_rs1, 3'b010, in_imm[4:0], OP_STORE};
            K_R:   enc_word = {1'b0, in_funct75, 5'b00000, in_rs2, in_rs1, in_funct3, in_rd, OP_ALU};
            K_I:   enc_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, OP_ALUI};
            K_BEQ, K_BNE, K_BLT: begin
                enc_word    = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, br_f3,
                               in_imm[4:1], in_imm[11], OP_BRANCH};
                enc_bad_off = in_imm[0];
            end
            default: enc_legal = 1'b0;
        endcase
    end

    assign count    = wr_ptr_q - rd_ptr_q;
    assign full     = (count == (PW+1)'(DEPTH));
    assign empty    = (count == '0);
    assign active   = (state_q != S_IDLE);
    assign cap_full = loaded_q[AW];

    assign in_ready = (state_q == S_LOAD) && !full;
    assign accept   = in_valid && in_ready;
    assign push     = accept && enc_legal;
    assign imem_we  = active && !empty && !cap_full;
    assign commit   = imem_we && imem_ready;
    // Once memory is full, heads are discarded so the session can still finish.
    assign pop      = commit || (active && !empty && cap_full);

    assign count_next = count + (PW+1)'(push) - (PW+1)'(pop);

    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q + (PW+1)'(push);
        rd_ptr_d = rd_ptr_q + (PW+1)'(pop);
        addr_d   = addr_q;
        loaded_d = loaded_q;
        err_d    = err_q;
        done_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d  = S_LOAD;
                    addr_d   = '0;
                    loaded_d = '0;
                    err_d    = 1'b0;
                end
            end
            S_LOAD: begin
                if (accept && in_last) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (count_next == '0) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (commit) begin
            loaded_d = loaded_q + (AW+1)'(1);
            if (addr_q != '1) begin
                addr_d = addr_q + AW'(1);
            end
        end
        if (accept && (!enc_legal || enc_bad_off)) begin
            err_d = 1'b1;
        end
        if (pop && cap_full) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            addr_q   <= '0;
            loaded_q <= '0;
            err_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            addr_q   <= addr_d;
            loaded_q <= loaded_d;
            err_q    <= err_d;
            done_q   <= done_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[wr_ptr_q[PW-1:0]] <= enc_word;
        end
    end

    assign imem_addr  = addr_q;
    assign imem_wdata = empty ? 32'h0 : fifo_q[rd_ptr_q[PW-1:0]];
    assign cpu_hold   = active;
    assign done       = done_q;
    assign err        = err_q;
    assign loaded     = loaded_q;

endmodule

// File: tb/tb_instr_loader.sv
// Self-checking bench for instr_loader: directed sessions plus randomized sessions
// compared against a field-level encoding model and an expected write list.
module tb_instr_loader;

   localparam int AW    = 6;
   localparam int DEPTH = 4;
   localparam int CAP   = 1 << AW;

   logic          clk        = 1'b0;
   logic          rst        = 1'b1;
   logic          start      = 1'b0;
   logic          in_valid   = 1'b0;
   logic          in_last    = 1'b0;
   logic [2:0]    in_kind    = '0;
   logic [4:0]    in_rd      = '0;
   logic [4:0]    in_rs1     = '0;
   logic [4:0]    in_rs2     = '0;
   logic [2:0]    in_funct3  = '0;
   logic          in_funct75 = 1'b0;
   logic [12:0]   in_imm     = '0;
   logic          imem_ready = 1'b0;
   logic          in_ready;
   logic          imem_we;
   logic [AW-1:0] imem_addr;
   logic [31:0]   imem_wdata;
   logic          cpu_hold;
   logic          done;
   logic          err;
   logic [AW:0]   loaded;

   int nChecks = 0;
   int nPass   = 0;
   int nFail   = 0;

   logic [31:0] expQ[$];
   logic [31:0] gotData[$];
   int          gotAddr[$];
   logic        errExp    = 1'b0;
   bit          readyRand = 1'b0;
   logic        readyForce = 1'b0;

   instr_loader #(.AW(AW), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .start(start),
      .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
      .in_kind(in_kind), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
      .in_funct3(in_funct3), .in_funct75(in_funct75), .in_imm(in_imm),
      .imem_we(imem_we), .imem_ready(imem_ready), .imem_addr(imem_addr),
      .imem_wdata(imem_wdata), .cpu_hold(cpu_hold), .done(done),
      .err(err), .loaded(loaded)
   );

   // Free-running clock.
   always #5 clk = ~clk;

   // Memory-side handshake: either held at a forced level or randomly throttled.
   always @(posedge clk) begin
      #2;
      imem_ready = readyRand ? ($urandom_range(0, 3) != 0) : readyForce;
   end

   // Instruction-memory model: records every write that will commit at the next edge.
   always @(negedge clk) begin
      if (!rst && imem_we && imem_ready) begin
         gotAddr.push_back(int'(imem_addr));
         gotData.push_back(imem_wdata);
      end
   end

   // Global time limit so the bench can never hang.
   initial begin
      #600000;
      $display("[TB] FAIL watchdog observed=timeout required=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Builds an RV32I word from the instruction fields with plain integer arithmetic.
   function automatic logic [31:0] refEncode(input int kind, input int rd, input int rs1,
                                             input int rs2, input int f3, input int f75,
                                             input int imm);
      logic [31:0] u;
      logic [31:0] w;
      int          bf3;
      u = imm;
      w = 32'h0;
      case (kind)
         0: w = ((u & 32'hFFF) << 20) | (rs1 << 15) | (2 << 12) | (rd << 7) | 32'h03;
         1: w = (((u >> 5) & 32'h7F) << 25) | (rs2 << 20) | (rs1 << 15) | (2 << 12)
                | ((u & 32'h1F) << 7) | 32'h23;
         2: w = (f75 << 30) | (rs2 << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 32'h33;
         3: w = ((u & 32'hFFF) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 32'h13;
         4, 5, 6: begin
            bf3 = (kind == 4) ? 0 : ((kind == 5) ? 1 : 4);
            u   = u & ~32'h1;
            w   = (((u >> 12) & 32'h1) << 31) | (((u >> 5) & 32'h3F) << 25) | (rs2 << 20)
                  | (rs1 << 15) | (bf3 << 12) | (((u >> 1) & 32'hF) << 8)
                  | (((u >> 11) & 32'h1) << 7) | 32'h63;
         end
         default: w = 32'h0;
      endcase
      return w;
   endfunction

   function automatic logic [31:0] gotAt(input int i);
      if (i < gotData.size()) return gotData[i];
      return 32'hDEADBEEF;
   endfunction

   function automatic logic [31:0] addrAt(input int i);
      if (i < gotAddr.size()) return gotAddr[i];
      return 32'hFFFFFFFF;
   endfunction

   // One comparison: counts it and reports any disagreement.
   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nChecks++;
      assert (obs === exp) nPass++;
      else begin
         nFail++;
         $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic nextEdge();
      @(posedge clk);
      #1;
   endtask

   // Opens a session and clears the per-session model.
   task automatic startSession();
      gotAddr.delete();
      gotData.delete();
      expQ.delete();
      errExp = 1'b0;
      start  = 1'b1;
      nextEdge();
      start  = 1'b0;
   endtask

   // Offers one bundle, waits (bounded) until it is taken, and updates the model.
   task automatic applyStimulus(input int kind, input int rd, input int rs1, input int rs2,
                                input int f3, input int f75, input int imm, input bit last,
                                output int waited);
      in_kind    = 3'(kind);
      in_rd      = 5'(rd);
      in_rs1     = 5'(rs1);
      in_rs2     = 5'(rs2);
      in_funct3  = 3'(f3);
      in_funct75 = 1'(f75);
      in_imm     = 13'(imm);
      in_last    = last;
      in_valid   = 1'b1;
      waited     = 0;
      while (in_ready !== 1'b1 && waited < 300) begin
         nextEdge();
         waited++;
      end
      if (waited >= 300) begin
         checkOutput("send_timeout", 32'(in_ready), 32'd1);
      end
      nextEdge();
      in_valid = 1'b0;
      in_last  = 1'b0;
      if (kind == 7) begin
         errExp = 1'b1;
      end else begin
         expQ.push_back(refEncode(kind, rd, rs1, rs2, f3, f75, imm));
         if (kind >= 4 && (imm % 2) != 0) errExp = 1'b1;
      end
   endtask

   // Waits (bounded) for the completion pulse and checks it lasts one cycle.
   task automatic waitDone();
      int n;
      n = 0;
      while (done !== 1'b1 && n < 500) begin
         nextEdge();
         n++;
      end
      checkOutput("done_pulse", 32'(done), 32'd1);
      checkOutput("hold_drops", 32'(cpu_hold), 32'd0);
      nextEdge();
      checkOutput("done_once", 32'(done), 32'd0);
   endtask

   // Compares the recorded writes with the expected word list for the session.
   task automatic finishSession(input string tag);
      int expN;
      if (expQ.size() > CAP) errExp = 1'b1;
      expN = (expQ.size() > CAP) ? CAP : expQ.size();
      checkOutput({tag, "_count"}, gotData.size(), expN);
      for (int i = 0; i < expN; i++) begin
         checkOutput({tag, "_addr"}, addrAt(i), i);
         checkOutput({tag, "_data"}, gotAt(i), expQ[i]);
      end
      checkOutput({tag, "_loaded"}, 32'(loaded), expN);
      checkOutput({tag, "_err"}, 32'(err), 32'(errExp));
   endtask

   // Directed sessions from the test plan, then randomized sessions and overflow.
   initial begin
      int w;
      int n;
      int kind;
      int imm;

      $display("[TB] start");
      repeat (3) nextEdge();
      rst = 1'b0;
      checkOutput("rst_in_ready", 32'(in_ready), 32'd0);
      checkOutput("rst_imem_we", 32'(imem_we), 32'd0);
      checkOutput("rst_imem_addr", 32'(imem_addr), 32'd0);
      checkOutput("rst_imem_wdata", imem_wdata, 32'd0);
      checkOutput("rst_cpu_hold", 32'(cpu_hold), 32'd0);
      checkOutput("rst_done", 32'(done), 32'd0);
      checkOutput("rst_err", 32'(err), 32'd0);
      checkOutput("rst_loaded", 32'(loaded), 32'd0);

      $display("[TB] single lw");
      readyForce = 1'b1;
      startSession();
      checkOutput("lw_hold", 32'(cpu_hold), 32'd1);
      checkOutput("lw_in_ready", 32'(in_ready), 32'd1);
      applyStimulus(0, 5, 1, 0, 0, 0, 8, 1'b1, w);
      checkOutput("lw_latency_we", 32'(imem_we), 32'd1);
      checkOutput("lw_addr", 32'(imem_addr), 32'd0);
      checkOutput("lw_wdata", imem_wdata, 32'h0080A283);
      checkOutput("lw_drain_ready", 32'(in_ready), 32'd0);
      waitDone();
      finishSession("lw");

      $display("[TB] streamed alu/store");
      startSession();
      applyStimulus(2, 3, 1, 2, 0, 0, 0, 1'b0, w);
      checkOutput("stream_wait0", w, 0);
      applyStimulus(2, 3, 1, 2, 0, 1, 0, 1'b0, w);
      checkOutput("stream_wait1", w, 0);
      applyStimulus(1, 0, 1, 2, 0, 0, 12, 1'b0, w);
      checkOutput("stream_wait2", w, 0);
      applyStimulus(3, 1, 0, 0, 0, 0, -1, 1'b1, w);
      checkOutput("stream_wait3", w, 0);
      waitDone();
      checkOutput("stream_add", gotAt(0), 32'h002081B3);
      checkOutput("stream_sub", gotAt(1), 32'h402081B3);
      checkOutput("stream_sw", gotAt(2), 32'h0020A623);
      checkOutput("stream_addi", gotAt(3), 32'hFFF00093);
      finishSession("stream");

      $display("[TB] branches");
      startSession();
      applyStimulus(4, 0, 1, 2, 0, 0, -8, 1'b0, w);
      applyStimulus(5, 0, 1, 2, 0, 0, -8, 1'b0, w);
      applyStimulus(6, 0, 1, 2, 0, 0, -8, 1'b1, w);
      waitDone();
      checkOutput("beq", gotAt(0), 32'hFE208CE3);
      checkOutput("bne", gotAt(1), 32'hFE209CE3);
      checkOutput("blt", gotAt(2), 32'hFE20CCE3);
      finishSession("branch");

      $display("[TB] stalled memory");
      readyForce = 1'b0;
      startSession();
      for (int i = 0; i < DEPTH; i++) begin
         applyStimulus(i % 4, i + 1, i + 2, i + 3, i, 0, 4 * i, 1'b0, w);
         checkOutput("stall_fill_wait", w, 0);
      end
      checkOutput("stall_full_ready", 32'(in_ready), 32'd0);
      checkOutput("stall_we", 32'(imem_we), 32'd1);
      checkOutput("stall_addr", 32'(imem_addr), 32'd0);
      nextEdge();
      checkOutput("stall_head_held", 32'(loaded), 32'd0);
      readyForce = 1'b1;
      applyStimulus(6, 0, 7, 8, 0, 0, 100, 1'b0, w);
      applyStimulus(3, 9, 10, 0, 5, 0, -300, 1'b1, w);
      waitDone();
      finishSession("stall");

      $display("[TB] error cases");
      startSession();
      applyStimulus(7, 1, 2, 3, 0, 0, 0, 1'b0, w);
      checkOutput("illegal_err", 32'(err), 32'd1);
      applyStimulus(4, 0, 3, 4, 0, 0, 5, 1'b1, w);
      waitDone();
      checkOutput("odd_branch_word", gotAt(0), refEncode(4, 0, 3, 4, 0, 0, 4));
      finishSession("errs");
      startSession();
      checkOutput("err_cleared", 32'(err), 32'd0);
      checkOutput("loaded_cleared", 32'(loaded), 32'd0);
      checkOutput("addr_cleared", 32'(imem_addr), 32'd0);
      applyStimulus(0, 2, 3, 0, 0, 0, -4, 1'b1, w);
      waitDone();
      finishSession("after_err");

      $display("[TB] reset during drain");
      readyForce = 1'b0;
      startSession();
      applyStimulus(0, 1, 1, 0, 0, 0, 1, 1'b0, w);
      applyStimulus(2, 2, 2, 2, 0, 0, 0, 1'b0, w);
      applyStimulus(3, 3, 3, 0, 0, 0, 3, 1'b1, w);
      readyForce = 1'b1;
      nextEdge();
      readyForce = 1'b0;
      nextEdge();
      checkOutput("pre_rst_loaded", 32'(loaded), 32'd1);
      checkOutput("pre_rst_addr", 32'(imem_addr), 32'd1);
      checkOutput("pre_rst_hold", 32'(cpu_hold), 32'd1);
      checkOutput("pre_rst_we", 32'(imem_we), 32'd1);
      rst = 1'b1;
      nextEdge();
      rst = 1'b0;
      checkOutput("abort_we", 32'(imem_we), 32'd0);
      checkOutput("abort_hold", 32'(cpu_hold), 32'd0);
      checkOutput("abort_loaded", 32'(loaded), 32'd0);
      checkOutput("abort_addr", 32'(imem_addr), 32'd0);
      checkOutput("abort_in_ready", 32'(in_ready), 32'd0);
      checkOutput("abort_done", 32'(done), 32'd0);
      readyForce = 1'b1;
      startSession();
      applyStimulus(1, 0, 5, 6, 0, 0, -20, 1'b1, w);
      waitDone();
      finishSession("post_abort");

      $display("[TB] random sessions");
      readyRand = 1'b1;
      for (int s = 0; s < 8; s++) begin
         startSession();
         n = $urandom_range(1, 12);
         for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, 2)) nextEdge();
            kind = ($urandom_range(0, 15) == 0) ? 7 : $urandom_range(0, 6);
            imm  = $urandom_range(0, 8191) - 4096;
            applyStimulus(kind, $urandom_range(0, 31), $urandom_range(0, 31),
                          $urandom_range(0, 31), $urandom_range(0, 7),
                          $urandom_range(0, 1), imm, i == n - 1, w);
         end
         waitDone();
         finishSession("rand");
      end
      readyRand = 1'b0;

      $display("[TB] capacity overflow");
      readyForce = 1'b1;
      startSession();
      for (int i = 0; i < CAP + 2; i++) begin
         applyStimulus(3, $urandom_range(0, 31), $urandom_range(0, 31), 0,
                       $urandom_range(0, 7), 0, $urandom_range(0, 4095) - 2048,
                       i == CAP + 1, w);
      end
      waitDone();
      checkOutput("ovf_addr_nowrap", 32'(imem_addr), CAP - 1);
      finishSession("ovf");

      $display("%0d/%0d checks passed", nPass, nChecks);
      $finish;
   end

endmodule
